// File: rtl/secuenciador_chocorrol_if.sv
// Program-load handshake between a loader and the sequencer.
//   CARGA_VALIDO : loader offers a program word
//   CARGA_DATO   : 20-bit program word
//   CARGA_LISTO  : sequencer accepts the word this cycle
// master = loader side, slave = sequencer side.
interface secuenciador_chocorrol_if;
  logic        CARGA_VALIDO;
  logic [19:0] CARGA_DATO;
  logic        CARGA_LISTO;

  modport master (output CARGA_VALIDO, output CARGA_DATO, input CARGA_LISTO);
  modport slave  (input CARGA_VALIDO, input CARGA_DATO, output CARGA_LISTO);
endinterface

// File: rtl/secuenciador_chocorrol.sv
// Micro-sequencer: buffers up to PROF 20-bit instruction words and replays
// them to a datapath, two cycles per word (LECTURA with the write-control
// field MC masked off so operands settle, then ESCRITURA with the word intact).
// The datapath result is captured at the end of each ESCRITURA.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   carga         : program-load handshake (slave side)
//   LIMPIAR       : empty the program buffer (idle only)
//   INICIO, PARAR : start / abort execution
//   INSTRUCCION   : word driven to datapath
//   RESULTADO     : datapath result
//   DATO_SALIDA   : last captured result, SALIDA_VALIDA pulses on update
//   OCUPADO       : executing
//   PC, LONGITUD  : executing index, loaded word count
//   CONTADOR      : completed instructions, wraps at 256
module secuenciador_chocorrol #(
  parameter int PROF = 16,
  parameter int AP   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  secuenciador_chocorrol_if.slave   carga,
  input  logic                      LIMPIAR,
  input  logic                      INICIO,
  input  logic                      PARAR,
  output logic [19:0]               INSTRUCCION,
  input  logic [31:0]               RESULTADO,
  output logic [31:0]               DATO_SALIDA,
  output logic                      SALIDA_VALIDA,
  output logic                      OCUPADO,
  output logic [AP-1:0]             PC,
  output logic [AP:0]               LONGITUD,
  output logic [7:0]                CONTADOR
);

  typedef enum logic [1:0] {INACTIVO, LECTURA, ESCRITURA} estado_t;

  localparam logic [AP:0] PROF_L = (AP+1)'(PROF);

  estado_t     estado, estado_sig;
  logic [19:0] buffer [PROF];
  logic        cargar, vaciar, arrancar, capturar, avanzar, ultima;

  assign OCUPADO = (estado != INACTIVO);
  assign ultima  = ({1'b0, PC} == (LONGITUD - 1'b1));

  always_ff @(posedge CLK) begin
    if (RST) estado <= INACTIVO;
    else     estado <= estado_sig;
  end

  always_comb begin
    estado_sig        = estado;
    INSTRUCCION       = '0;
    carga.CARGA_LISTO = 1'b0;
    cargar            = 1'b0;
    vaciar            = 1'b0;
    arrancar          = 1'b0;
    capturar          = 1'b0;
    avanzar           = 1'b0;
    case (estado)
      INACTIVO: begin
        // Clear and start both outrank loading, so they also drop LISTO.
        carga.CARGA_LISTO = (LONGITUD < PROF_L) && !INICIO && !LIMPIAR;
        cargar            = carga.CARGA_VALIDO && carga.CARGA_LISTO;
        if (LIMPIAR) vaciar = 1'b1;
        else if (INICIO && (LONGITUD != '0)) begin
          arrancar   = 1'b1;
          estado_sig = LECTURA;
        end
      end
      LECTURA: begin
        INSTRUCCION = {2'b00, buffer[PC][17:0]};
        estado_sig  = PARAR ? INACTIVO : ESCRITURA;
      end
      ESCRITURA: begin
        INSTRUCCION = buffer[PC];
        capturar    = 1'b1;
        // An abort here still lets the current word complete.
        if (PARAR || ultima) estado_sig = INACTIVO;
        else begin
          avanzar    = 1'b1;
          estado_sig = LECTURA;
        end
      end
      default: estado_sig = INACTIVO;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PC            <= '0;
      LONGITUD      <= '0;
      DATO_SALIDA   <= '0;
      SALIDA_VALIDA <= 1'b0;
      CONTADOR      <= '0;
    end else begin
      SALIDA_VALIDA <= capturar;
      if (vaciar)      LONGITUD <= '0;
      else if (cargar) LONGITUD <= LONGITUD + 1'b1;
      if (arrancar)     PC <= '0;
      else if (avanzar) PC <= PC + 1'b1;
      if (capturar) begin
        DATO_SALIDA <= RESULTADO;
        CONTADOR    <= CONTADOR + 8'd1;
      end
    end
  end

  // Buffer has no reset; contents survive between runs.
  always_ff @(posedge CLK) begin
    if (cargar && !RST) buffer[LONGITUD[AP-1:0]] <= carga.CARGA_DATO;
  end

endmodule

// File: tb/tb_secuenciador_chocorrol.sv
module tb_secuenciador_chocorrol;
  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst, limpiar, inicio, parar, override;
  logic [19:0] instruccion;
  logic [31:0] resultado, dato_salida;
  logic        salida_valida, ocupado;
  logic [3:0]  pc;
  logic [4:0]  longitud;
  logic [7:0]  contador;

  int tests = 0, fails = 0, pulses = 0, exp_cnt = 0;
  logic prev_sv = 1'b0;
  logic [31:0] sb [$];

  secuenciador_chocorrol_if bus();

  secuenciador_chocorrol #(.PROF(16), .AP(4)) dut (
    .CLK(clk), .RST(rst), .carga(bus), .LIMPIAR(limpiar), .INICIO(inicio),
    .PARAR(parar), .INSTRUCCION(instruccion), .RESULTADO(resultado),
    .DATO_SALIDA(dato_salida), .SALIDA_VALIDA(salida_valida), .OCUPADO(ocupado),
    .PC(pc), .LONGITUD(longitud), .CONTADOR(contador)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: result derived from the word on the bus.
  assign resultado = override ? 32'hDEADBEEF : ({12'h0, instruccion} ^ K);

  // Scoreboard: every pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (salida_valida === 1'b1) begin
      logic [31:0] e;
      pulses++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse dato=%h (no result expected)", dato_salida);
      end else begin
        e = sb.pop_front();
        if (dato_salida !== e) begin
          fails++;
          $display("FAIL dato_salida got=%h exp=%h", dato_salida, e);
        end
      end
      tests++;
      if (prev_sv === 1'b1) begin
        fails++;
        $display("FAIL pulse_twice got=consecutive exp=single");
      end
    end
    prev_sv = salida_valida;
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [19:0] w);
    bus.CARGA_VALIDO = 1'b1; bus.CARGA_DATO = w;
    step();
    bus.CARGA_VALIDO = 1'b0;
  endtask

  task automatic clear_buf;
    limpiar = 1'b1; step(); limpiar = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; step(); step(); rst = 1'b0;
    tests++;
    if (ocupado !== 1'b0 || instruccion !== 20'h0 || pc !== 4'd0 || longitud !== 5'd0 ||
        dato_salida !== 32'h0 || salida_valida !== 1'b0 || contador !== 8'd0) begin
      fails++;
      $display("FAIL reset got ocu=%b ins=%h pc=%0d len=%0d dato=%h sv=%b cnt=%0d exp all zero",
               ocupado, instruccion, pc, longitud, dato_salida, salida_valida, contador);
    end
  endtask

  task automatic test_basic;
    logic [19:0] w [3];
    logic [19:0] ei;
    int base;
    w[0] = {2'b01, 18'($urandom)};
    w[1] = {2'b01, 18'($urandom)};
    w[2] = {2'b10, 18'($urandom)};
    for (int i = 0; i < 3; i++) load_word(w[i]);
    for (int i = 0; i < 3; i++) begin sb.push_back({12'h0, w[i]} ^ K); exp_cnt++; end
    base = pulses;
    inicio = 1'b1; step(); inicio = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ei = (i % 2 == 0) ? {2'b00, w[i/2][17:0]} : w[i/2];
      tests++;
      if (ocupado !== 1'b1 || instruccion !== ei || pc !== 4'(i/2)) begin
        fails++;
        $display("FAIL basic_cycle%0d got ocu=%b ins=%h pc=%0d exp ocu=1 ins=%h pc=%0d",
                 i, ocupado, instruccion, pc, ei, i/2);
      end
      step();
    end
    tests++;
    if (ocupado !== 1'b0 || instruccion !== 20'h0 || contador !== 8'(exp_cnt) || longitud !== 5'd3 || pc !== 4'd2) begin
      fails++;
      $display("FAIL basic_end got ocu=%b ins=%h cnt=%0d len=%0d pc=%0d exp 0 0 %0d 3 2",
               ocupado, instruccion, contador, longitud, pc, exp_cnt);
    end
    step();
    tests++;
    if (pulses - base !== 3) begin
      fails++; $display("FAIL basic_pulses got=%0d exp=3", pulses - base);
    end
  endtask

  task automatic test_full;
    int acc = 0;
    clear_buf();
    for (int i = 0; i < 17; i++) begin
      bus.CARGA_VALIDO = 1'b1; bus.CARGA_DATO = 20'(i * 3 + 1);
      #1;
      if (bus.CARGA_LISTO === 1'b1) acc++;
      if (i == 16) begin
        tests++;
        if (bus.CARGA_LISTO !== 1'b0) begin
          fails++; $display("FAIL full_listo17 got=%b exp=0", bus.CARGA_LISTO);
        end
      end
      step();
    end
    bus.CARGA_VALIDO = 1'b0;
    tests++;
    if (acc != 16 || longitud !== 5'd16) begin
      fails++; $display("FAIL full_count got acc=%0d len=%0d exp 16 16", acc, longitud);
    end
  endtask

  task automatic test_empty_start;
    clear_buf();
    inicio = 1'b1; step(); inicio = 1'b0;
    tests++;
    if (ocupado !== 1'b0 || instruccion !== 20'h0 || longitud !== 5'd0) begin
      fails++; $display("FAIL empty_start got ocu=%b ins=%h len=%0d exp 0 0 0", ocupado, instruccion, longitud);
    end
  endtask

  task automatic test_parar;
    logic [19:0] w [3];
    int base;
    clear_buf();
    for (int i = 0; i < 3; i++) begin w[i] = {2'b11, 18'($urandom)}; load_word(w[i]); end
    // abort in LECTURA of word 1
    base = pulses;
    sb.push_back({12'h0, w[0]} ^ K); exp_cnt++;
    inicio = 1'b1; step(); inicio = 1'b0;
    step(); step();
    parar = 1'b1; step(); parar = 1'b0;
    tests++;
    if (ocupado !== 1'b0 || pc !== 4'd1) begin
      fails++; $display("FAIL parar_lect got ocu=%b pc=%0d exp 0 1", ocupado, pc);
    end
    step(); step();
    tests++;
    if (pulses - base !== 1 || contador !== 8'(exp_cnt)) begin
      fails++; $display("FAIL parar_lect_cnt got pulses=%0d cnt=%0d exp 1 %0d", pulses - base, contador, exp_cnt);
    end
    // abort in ESCRITURA of word 1
    base = pulses;
    sb.push_back({12'h0, w[0]} ^ K); sb.push_back({12'h0, w[1]} ^ K); exp_cnt += 2;
    inicio = 1'b1; step(); inicio = 1'b0;
    step(); step(); step();
    parar = 1'b1; step(); parar = 1'b0;
    tests++;
    if (ocupado !== 1'b0 || pc !== 4'd1) begin
      fails++; $display("FAIL parar_escr got ocu=%b pc=%0d exp 0 1", ocupado, pc);
    end
    step(); step();
    tests++;
    if (pulses - base !== 2 || contador !== 8'(exp_cnt)) begin
      fails++; $display("FAIL parar_escr_cnt got pulses=%0d cnt=%0d exp 2 %0d", pulses - base, contador, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    clear_buf();
    load_word(20'hC1234);
    inicio = 1'b1; step(); inicio = 1'b0;
    step();
    override = 1'b1; rst = 1'b1; step(); rst = 1'b0;
    exp_cnt = 0;
    tests++;
    if (dato_salida !== 32'h0 || salida_valida !== 1'b0 || contador !== 8'd0 ||
        longitud !== 5'd0 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got dato=%h sv=%b cnt=%0d len=%0d ocu=%b exp all zero",
               dato_salida, salida_valida, contador, longitud, ocupado);
    end
    override = 1'b0;
    step();
  endtask

  task automatic test_wrap;
    logic [19:0] w;
    w = {2'b01, 18'($urandom)};
    load_word(w);
    for (int i = 0; i < 256; i++) begin
      sb.push_back({12'h0, w} ^ K); exp_cnt++;
      inicio = 1'b1; step(); inicio = 1'b0;
      step(); step();
      if (i == 254) begin
        tests++;
        if (contador !== 8'd255) begin
          fails++; $display("FAIL wrap_255 got=%0d exp=255", contador);
        end
      end
    end
    tests++;
    if (contador !== 8'(exp_cnt) || contador !== 8'd0 || longitud !== 5'd1) begin
      fails++; $display("FAIL wrap_0 got cnt=%0d len=%0d exp 0 1", contador, longitud);
    end
    step();
  endtask

  task automatic test_prio;
    limpiar = 1'b1; inicio = 1'b1;
    bus.CARGA_VALIDO = 1'b1; bus.CARGA_DATO = 20'hABCDE;
    #1;
    tests++;
    if (bus.CARGA_LISTO !== 1'b0) begin
      fails++; $display("FAIL prio_listo got=%b exp=0", bus.CARGA_LISTO);
    end
    step();
    limpiar = 1'b0; inicio = 1'b0; bus.CARGA_VALIDO = 1'b0;
    tests++;
    if (longitud !== 5'd0 || ocupado !== 1'b0) begin
      fails++; $display("FAIL prio got len=%0d ocu=%b exp 0 0", longitud, ocupado);
    end
    step();
    tests++;
    if (ocupado !== 1'b0 || instruccion !== 20'h0 || sb.size() != 0) begin
      fails++; $display("FAIL prio_idle got ocu=%b ins=%h pending=%0d exp 0 0 0", ocupado, instruccion, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; limpiar = 1'b0; inicio = 1'b0; parar = 1'b0; override = 1'b0;
    bus.CARGA_VALIDO = 1'b0; bus.CARGA_DATO = '0;
    test_reset();
    test_basic();
    test_full();
    test_empty_start();
    test_parar();
    test_reset_mid();
    test_wrap();
    test_prio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/secuenciador_chocorrol.md
SECUENCIADOR_CHOCORROL -- requirements
Module: secuenciador_chocorrol

Interface
REQ-001 SHALL have parameter PROF, default 16, program buffer depth in 20-bit instruction words.
REQ-002 SHALL have parameter AP, default 4, width of PC (log2 PROF).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CARGA_VALIDO  input  1  program word offered.
REQ-006 SHALL have port CARGA_DATO  input  20  program word, format MC[19:18] OP1[17:13] ALUC[12:10] OP2[9:5] MB[4:0].
REQ-007 SHALL have port CARGA_LISTO  output  1  buffer accepts a word this cycle.
REQ-008 SHALL have port LIMPIAR  input  1  empty program buffer.
REQ-009 SHALL have port INICIO  input  1  start execution of loaded program.
REQ-010 SHALL have port PARAR  input  1  abort execution.
REQ-011 SHALL have port INSTRUCCION  output  20  word driven to datapath.
REQ-012 SHALL have port RESULTADO  input  32  datapath result.
REQ-013 SHALL have port DATO_SALIDA  output  32  last captured result.
REQ-014 SHALL have port SALIDA_VALIDA  output  1  one-cycle pulse, DATO_SALIDA updated.
REQ-015 SHALL have port OCUPADO  output  1  high in LECTURA or ESCRITURA.
REQ-016 SHALL have port PC  output  AP  index of executing word.
REQ-017 SHALL have port LONGITUD  output  AP+1  words loaded, 0..PROF.
REQ-018 SHALL have port CONTADOR  output  8  instructions completed since reset, wraps 255->0.

Function
REQ-019 SHALL implement states INACTIVO, LECTURA, ESCRITURA; each instruction takes exactly 2 cycles (LECTURA then ESCRITURA).
REQ-020 INACTIVO: INSTRUCCION SHALL be 20'h00000; CARGA_LISTO = (LONGITUD<PROF) and !INICIO and !LIMPIAR; CARGA_LISTO=0 in other states.
REQ-021 CARGA_VALIDO&&CARGA_LISTO SHALL write CARGA_DATO to buffer[LONGITUD] and increment LONGITUD; at LONGITUD==PROF words are refused, LONGITUD unchanged.
REQ-022 LIMPIAR in INACTIVO SHALL set LONGITUD=0 next cycle; LIMPIAR ignored in other states; priority LIMPIAR > INICIO > load.
REQ-023 INICIO in INACTIVO with LONGITUD>0 SHALL set PC=0 and enter LECTURA next cycle; with LONGITUD==0 ignored, state stays INACTIVO.
REQ-024 LECTURA: INSTRUCCION SHALL be {2'b00, buffer[PC][17:0]} (no write enable, operands settle); next state ESCRITURA.
REQ-025 ESCRITURA: INSTRUCCION SHALL be buffer[PC] unmodified; at cycle end DATO_SALIDA<=RESULTADO, SALIDA_VALIDA=1 following cycle only, CONTADOR increments.
REQ-026 After ESCRITURA: PC==LONGITUD-1 -> INACTIVO, PC held; else PC+1, LECTURA.
REQ-027 PARAR in LECTURA SHALL go to INACTIVO next cycle with no ESCRITURA, no capture, CONTADOR unchanged.
REQ-028 PARAR in ESCRITURA SHALL let that instruction complete (capture, count) then go to INACTIVO.
REQ-029 INICIO while OCUPADO SHALL be ignored; buffer contents SHALL be preserved across runs (rerun needs no reload).
REQ-030 SALIDA_VALIDA SHALL pulse once per completed instruction, never two consecutive cycles.

Reset
REQ-031 RST SHALL, next edge, force INACTIVO, INSTRUCCION=0, PC=0, LONGITUD=0, DATO_SALIDA=0, SALIDA_VALIDA=0, CONTADOR=0, OCUPADO=0; buffer contents undefined.
REQ-032 RST mid-execution SHALL abort with no capture; RST overrides all other inputs.

Verification
REQ-033 Load 3 words (MC=01,01,10), INICIO -> OCUPADO 6 cycles, INSTRUCCION MC pattern 00,01,00,01,00,10, 3 SALIDA_VALIDA pulses, CONTADOR=3, LONGITUD=3.
REQ-034 Offer 17 words with CARGA_VALIDO held -> 16 accepted, CARGA_LISTO=0 after 16th, LONGITUD=16.
REQ-035 INICIO with LONGITUD=0 -> stays INACTIVO, OCUPADO=0, INSTRUCCION=0.
REQ-036 PARAR during LECTURA of word 1 -> 1 pulse total, INACTIVO, PC=1; PARAR during ESCRITURA of word 1 -> 2 pulses, PC=1.
REQ-037 RST in ESCRITURA with RESULTADO=32'hDEADBEEF -> DATO_SALIDA=0, SALIDA_VALIDA=0, CONTADOR=0, LONGITUD=0 next cycle.
REQ-038 Run 1-word program 256 times -> CONTADOR wraps to 0; LIMPIAR+INICIO+CARGA_VALIDO same cycle -> LONGITUD=0, no start, no load.
